// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the register-file write-back slice:
// load funct3 encodings, write-back FSM states and the register index type.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/half lane of a raw memory
// word and sign- or zero-extends it; flags funct3 values that are not loads.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = rdata[{addr_lo, 3'b000} +: 8];
    // Halves are selected by addr_lo[1] only; a misaligned addr_lo[0] is ignored.
    lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'b0, lane_b};
      F3_LHU:  data = {16'b0, lane_h};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side driver of the RV32IC register file: ALU results pass through,
// loads wait for a variable-latency memory response before being written.
module regfile_writeback
  import rv32_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  ex_is_load,
  input  logic [2:0]            ex_funct3,
  input  logic [1:0]            ex_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic                  load_pending,
  output logic [ADDR_WIDTH-1:0] pending_rd,
  output logic                  load_fault
);

  localparam int                CNT_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_lo;
  logic [2:0]       al_f3;
  logic [1:0]       al_lo;
  logic [31:0]      al_data;
  logic             al_illegal;

  // Handshake: an instruction transfers on a rising edge where ex_valid and
  // ex_ready are both 1. ex_ready is 1 only in IDLE outside reset and does not
  // depend on ex_valid; the offer is free to change when no transfer happens.
  assign ex_ready = rst_n && (state == IDLE);

  // The single aligner checks the offered funct3 in IDLE and formats the
  // response with the captured fields while waiting.
  assign al_f3 = (state == IDLE) ? ex_funct3  : cap_f3;
  assign al_lo = (state == IDLE) ? ex_addr_lo : cap_lo;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .funct3  (al_f3),
    .addr_lo (al_lo),
    .data    (al_data),
    .illegal (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_f3        <= '0;
      cap_lo        <= '0;
      rf_we         <= 1'b0;
      rf_write_addr <= '0;
      rf_din        <= '0;
      load_pending  <= 1'b0;
      pending_rd    <= '0;
      load_fault    <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!ex_is_load) begin
              rf_we         <= (ex_rd != '0);
              rf_write_addr <= ex_rd;
              rf_din        <= ex_result;
            end else if (al_illegal) begin
              load_fault <= 1'b1;
            end else begin
              state        <= WAIT_LOAD;
              cnt          <= '0;
              cap_f3       <= ex_funct3;
              cap_lo       <= ex_addr_lo;
              load_pending <= 1'b1;
              pending_rd   <= ex_rd;
            end
          end
        end
        WAIT_LOAD: begin
          // A response on the timeout cycle still wins over the fault.
          if (mem_rvalid) begin
            state         <= IDLE;
            load_pending  <= 1'b0;
            rf_we         <= (pending_rd != '0);
            rf_write_addr <= pending_rd;
            rf_din        <= al_data;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            load_pending <= 1'b0;
            load_fault   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
